// File: rtl/alu_mem_sequencer_if.sv
// Command, status, ALU and memory signals of the ALU/memory sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface alu_mem_sequencer_if;
    // Command request
    logic        start;
    logic [3:0]  cmd_op;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [4:0]  len;
    logic [31:0] cmd_b;
    logic [31:0] cmd_imm;

    // Status
    logic        busy;
    logic        done;
    logic        err;

    // External ALU
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_imm;
    logic [31:0] alu_result;

    // External memory, written level-sensitively
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    modport slave (
        input  start, cmd_op, src_addr, dst_addr, len, cmd_b, cmd_imm,
        input  alu_result, mem_read_data,
        output busy, done, err,
        output alu_op, alu_a, alu_b, alu_imm,
        output mem_address, mem_write_data, mem_write_enable
    );

    modport master (
        output start, cmd_op, src_addr, dst_addr, len, cmd_b, cmd_imm,
        output alu_result, mem_read_data,
        input  busy, done, err,
        input  alu_op, alu_a, alu_b, alu_imm,
        input  mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/alu_mem_sequencer.sv
// ALU/memory sequencer: for each element i < len, reads src+4*i, runs the
// latched ALU operation against it and writes the result to dst+4*i.
// Every output comes straight from a flop, so the level-sensitive memory
// never sees a combinational path from any input.
module alu_mem_sequencer (
    input  logic                  clk,
    input  logic                  rst,
    alu_mem_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q;

    // Command parameters latched when a command is accepted
    logic [3:0]  op_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [4:0]  len_q;
    logic [31:0] b_q;
    logic [31:0] imm_q;
    logic [4:0]  i_q;

    // Registered outputs
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [3:0]  alu_op_q;
    logic [31:0] alu_a_q;      // doubles as operand register A
    logic [31:0] alu_b_q;
    logic [31:0] alu_imm_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_write_data_q;  // doubles as the captured ALU result
    logic        mem_write_enable_q;

    // Next-element helpers
    logic        illegal_d;
    logic        empty_d;
    logic [5:0]  i_inc_d;
    logic        more_d;
    logic [31:0] src_next_d;
    logic [31:0] dst_cur_d;

    // Decode of the incoming command and address arithmetic for the current
    // and next element; the adders wrap modulo 2^32 by construction.
    always_comb begin
        illegal_d  = (bus.cmd_op > 4'd3);
        empty_d    = (bus.len == 5'd0);
        i_inc_d    = {1'b0, i_q} + 6'd1;
        more_d     = (i_inc_d < {1'b0, len_q});
        src_next_d = src_q + {24'd0, i_inc_d, 2'b00};
        dst_cur_d  = dst_q + {25'd0, i_q, 2'b00};
    end

    // Sequencer FSM; every output is updated on the edge entering the state
    // in which it must be valid, and otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            op_q               <= 4'd0;
            src_q              <= 32'd0;
            dst_q              <= 32'd0;
            len_q              <= 5'd0;
            b_q                <= 32'd0;
            imm_q              <= 32'd0;
            i_q                <= 5'd0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            err_q              <= 1'b0;
            alu_op_q           <= 4'd0;
            alu_a_q            <= 32'd0;
            alu_b_q            <= 32'd0;
            alu_imm_q          <= 32'd0;
            mem_address_q      <= 32'd0;
            mem_write_data_q   <= 32'd0;
            mem_write_enable_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.cmd_op;
                        src_q <= bus.src_addr;
                        dst_q <= bus.dst_addr;
                        len_q <= bus.len;
                        b_q   <= bus.cmd_b;
                        imm_q <= bus.cmd_imm;
                        i_q   <= 5'd0;
                        if (empty_d || illegal_d) begin
                            // Nothing to process: the very next cycle is DONE,
                            // whose own status (busy low, done high) takes over.
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= illegal_d;
                            state_q <= S_DONE;
                        end else begin
                            busy_q        <= 1'b1;
                            mem_address_q <= bus.src_addr;
                            state_q       <= S_READ;
                        end
                    end
                end

                S_READ: begin
                    alu_a_q   <= bus.mem_read_data;
                    alu_op_q  <= op_q;
                    alu_b_q   <= b_q;
                    alu_imm_q <= imm_q;
                    state_q   <= S_EXEC;
                end

                S_EXEC: begin
                    mem_write_data_q   <= bus.alu_result;
                    mem_address_q      <= dst_cur_d;
                    mem_write_enable_q <= 1'b1;
                    state_q            <= S_WRITE;
                end

                S_WRITE: begin
                    mem_write_enable_q <= 1'b0;
                    i_q                <= i_inc_d[4:0];
                    if (more_d) begin
                        mem_address_q <= src_next_d;
                        state_q       <= S_READ;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    // start is not sampled here, so a request in DONE is dropped
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.err              = err_q;
    assign bus.alu_op           = alu_op_q;
    assign bus.alu_a            = alu_a_q;
    assign bus.alu_b            = alu_b_q;
    assign bus.alu_imm          = alu_imm_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_data   = mem_write_data_q;
    assign bus.mem_write_enable = mem_write_enable_q;

endmodule
